// File: rtl/branch_resolve.sv
// Execute-stage control-flow resolution: computes branch/jump targets, holds a
// redirect request to fetch, squashes younger work, and reports links/misaligned faults.
module branch_resolve #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [1:0]       ex_kind,
    input  logic             br_en,
    input  logic [31:0]      pc_ex,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             squash,
    output logic             link_valid,
    output logic [31:0]      link_data,
    output logic             exc_misaligned,
    output logic [31:0]      exc_tval,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int unsigned XLEN = 32;
    localparam logic [1:0] KIND_BR   = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b11;

    typedef enum logic {IDLE, REDIRECT} state_e;

    state_e            state_q, state_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              squash_q, squash_d;
    logic              link_valid_q, link_valid_d;
    logic [XLEN-1:0]   link_data_q, link_data_d;
    logic              exc_q, exc_d;
    logic [XLEN-1:0]   exc_tval_q, exc_tval_d;
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

    logic              accept;
    logic              is_branch;
    logic              taken;
    logic              misaligned;
    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   target;

    // Target resolution; jalr clears bit 0 of the sum.
    assign accept     = ex_valid & (state_q == IDLE);
    assign is_branch  = (ex_kind == KIND_BR);
    assign taken      = (is_branch & br_en) | ex_kind[1];
    assign jalr_sum   = rs1 + imm;
    assign target     = (ex_kind == KIND_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_ex + imm);
    assign misaligned = taken & target[1];

    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        link_valid_d     = 1'b0;
        link_data_d      = link_data_q;
        exc_d            = 1'b0;
        exc_tval_d       = exc_tval_q;
        branch_cnt_d     = branch_cnt_q;
        taken_cnt_d      = taken_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_branch) begin
                        branch_cnt_d = branch_cnt_q + CNT_W'(1);
                        if (br_en) taken_cnt_d = taken_cnt_q + CNT_W'(1);
                    end
                    if (taken) begin
                        if (misaligned) begin
                            exc_d      = 1'b1;
                            exc_tval_d = target;
                        end else begin
                            state_d       = REDIRECT;
                            redirect_pc_d = target;
                            if (ex_kind[1]) begin
                                link_valid_d = 1'b1;
                                link_data_d  = pc_ex + XLEN'(4);
                            end
                        end
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Squash covers the slot after any taken accept and every redirect cycle.
        redirect_valid_d = (state_d == REDIRECT);
        squash_d         = (accept & taken) | (state_d == REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            squash_q         <= 1'b0;
            link_valid_q     <= 1'b0;
            link_data_q      <= '0;
            exc_q            <= 1'b0;
            exc_tval_q       <= '0;
            branch_cnt_q     <= '0;
            taken_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            squash_q         <= squash_d;
            link_valid_q     <= link_valid_d;
            link_data_q      <= link_data_d;
            exc_q            <= exc_d;
            exc_tval_q       <= exc_tval_d;
            branch_cnt_q     <= branch_cnt_d;
            taken_cnt_q      <= taken_cnt_d;
        end
    end

    assign ex_ready       = (state_q == IDLE);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign squash         = squash_q;
    assign link_valid     = link_valid_q;
    assign link_data      = link_data_q;
    assign exc_misaligned = exc_q;
    assign exc_tval       = exc_tval_q;
    assign branch_cnt     = branch_cnt_q;
    assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a behavioural model.
module tb_branch_resolve;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ex_valid = 1'b0;
    logic             ex_ready;
    logic [1:0]       ex_kind = 2'b00;
    logic             br_en = 1'b0;
    logic [31:0]      pc_ex = '0;
    logic [31:0]      imm = '0;
    logic [31:0]      rs1 = '0;
    logic             redirect_valid;
    logic             redirect_ready = 1'b0;
    logic [31:0]      redirect_pc;
    logic             squash;
    logic             link_valid;
    logic [31:0]      link_data;
    logic             exc_misaligned;
    logic [31:0]      exc_tval;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int total = 0;
    int bad   = 0;

    branch_resolve #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_kind(ex_kind), .br_en(br_en),
        .pc_ex(pc_ex), .imm(imm), .rs1(rs1),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .squash(squash),
        .link_valid(link_valid), .link_data(link_data),
        .exc_misaligned(exc_misaligned), .exc_tval(exc_tval),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: a pending-redirect flag plus last-seen results.
    bit          m_init = 0;
    bit          m_busy = 0;
    bit          m_sq = 0, m_lv = 0, m_em = 0;
    logic [31:0] m_rpc = '0, m_ld = '0, m_tval = '0;
    int          m_bcnt = 0, m_tcnt = 0;

    always @(posedge clk) begin
        logic [31:0] tgt;
        bit          tk, acc;
        if (rst) begin
            m_init = 1; m_busy = 0; m_sq = 0; m_lv = 0; m_em = 0;
            m_rpc = '0; m_ld = '0; m_tval = '0; m_bcnt = 0; m_tcnt = 0;
        end else begin
            acc  = ex_valid && !m_busy;
            tk   = (ex_kind == 2'd1 && br_en) || ex_kind == 2'd2 || ex_kind == 2'd3;
            tgt  = (ex_kind == 2'd3) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc_ex + imm);
            m_lv = 0; m_em = 0; m_sq = 0;
            if (m_busy) begin
                if (redirect_ready) m_busy = 0;
            end else if (acc) begin
                if (ex_kind == 2'd1) begin
                    m_bcnt = (m_bcnt + 1) % 16;
                    if (br_en) m_tcnt = (m_tcnt + 1) % 16;
                end
                if (tk) begin
                    m_sq = 1;
                    if (tgt[1]) begin
                        m_em = 1; m_tval = tgt;
                    end else begin
                        m_busy = 1; m_rpc = tgt;
                        if (ex_kind >= 2'd2) begin
                            m_lv = 1; m_ld = pc_ex + 32'd4;
                        end
                    end
                end
            end
            if (m_busy) m_sq = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("ex_ready",       32'(ex_ready),       32'(!m_busy));
            chk("redirect_valid", 32'(redirect_valid), 32'(m_busy));
            chk("redirect_pc",    redirect_pc,         m_rpc);
            chk("squash",         32'(squash),         32'(m_sq));
            chk("link_valid",     32'(link_valid),     32'(m_lv));
            chk("link_data",      link_data,           m_ld);
            chk("exc_misaligned", 32'(exc_misaligned), 32'(m_em));
            chk("exc_tval",       exc_tval,            m_tval);
            chk("branch_cnt",     32'(branch_cnt),     32'(m_bcnt));
            chk("taken_cnt",      32'(taken_cnt),      32'(m_tcnt));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [1:0] k, input logic b, input logic [31:0] pc,
                         input logic [31:0] im, input logic [31:0] r1);
        ex_valid = 1'b1; ex_kind = k; br_en = b; pc_ex = pc; imm = im; rs1 = r1;
    endtask

    initial begin
        rst = 1'b1; step(); step(); rst = 1'b0;
        @(negedge clk);
        chk("lit_reset_ready", 32'(ex_ready), 32'd1);
        chk("lit_reset_rv",    32'(redirect_valid), 32'd0);

        // Taken beq
        redirect_ready = 1'b1;
        issue(2'd1, 1'b1, 32'h100, 32'h40, 32'h0);
        step(); ex_valid = 1'b0;
        @(negedge clk);
        chk("lit_beq_rv",    32'(redirect_valid), 32'd1);
        chk("lit_beq_pc",    redirect_pc, 32'h140);
        chk("lit_beq_sq",    32'(squash), 32'd1);
        chk("lit_beq_ready", 32'(ex_ready), 32'd0);
        step(); @(negedge clk);
        chk("lit_beq_rv2",   32'(redirect_valid), 32'd0);
        chk("lit_beq_sq2",   32'(squash), 32'd0);
        chk("lit_beq_rdy2",  32'(ex_ready), 32'd1);
        chk("lit_beq_bcnt",  32'(branch_cnt), 32'd1);
        chk("lit_beq_tcnt",  32'(taken_cnt), 32'd1);

        // Not-taken branch
        issue(2'd1, 1'b0, 32'h200, 32'h40, 32'h0);
        step(); ex_valid = 1'b0; @(negedge clk);
        chk("lit_nt_rv",   32'(redirect_valid), 32'd0);
        chk("lit_nt_sq",   32'(squash), 32'd0);
        chk("lit_nt_bcnt", 32'(branch_cnt), 32'd2);
        chk("lit_nt_tcnt", 32'(taken_cnt), 32'd1);

        // jalr with bit 0 cleared
        issue(2'd3, 1'b0, 32'h300, 32'h4, 32'h1001);
        step(); ex_valid = 1'b0; @(negedge clk);
        chk("lit_jalr_pc", redirect_pc, 32'h1004);
        chk("lit_jalr_lv", 32'(link_valid), 32'd1);
        chk("lit_jalr_ld", link_data, 32'h304);
        step(); @(negedge clk);
        chk("lit_jalr_lv2", 32'(link_valid), 32'd0);
        chk("lit_jalr_ld2", link_data, 32'h304);

        // Misaligned jal
        issue(2'd2, 1'b0, 32'h400, 32'h2, 32'h0);
        step(); ex_valid = 1'b0; @(negedge clk);
        chk("lit_mis_em",    32'(exc_misaligned), 32'd1);
        chk("lit_mis_tval",  exc_tval, 32'h402);
        chk("lit_mis_sq",    32'(squash), 32'd1);
        chk("lit_mis_rv",    32'(redirect_valid), 32'd0);
        chk("lit_mis_lv",    32'(link_valid), 32'd0);
        chk("lit_mis_ready", 32'(ex_ready), 32'd1);
        step(); @(negedge clk);
        chk("lit_mis_sq2", 32'(squash), 32'd0);
        chk("lit_mis_em2", 32'(exc_misaligned), 32'd0);

        // Back-pressure on a jal to 0x800; a held branch must not be taken in
        redirect_ready = 1'b0;
        issue(2'd2, 1'b0, 32'h7F0, 32'h10, 32'h0);
        step();
        issue(2'd1, 1'b1, 32'h900, 32'h8, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_bp_rv",    32'(redirect_valid), 32'd1);
            chk("lit_bp_sq",    32'(squash), 32'd1);
            chk("lit_bp_pc",    redirect_pc, 32'h800);
            chk("lit_bp_ready", 32'(ex_ready), 32'd0);
            if (i == 3) redirect_ready = 1'b1;
            step();
        end
        ex_valid = 1'b0;
        @(negedge clk);
        chk("lit_bp_idle", 32'(ex_ready), 32'd1);
        chk("lit_bp_bcnt", 32'(branch_cnt), 32'd2);

        // Reset while redirecting
        redirect_ready = 1'b0;
        issue(2'd2, 1'b0, 32'h10, 32'h20, 32'h0);
        step(); ex_valid = 1'b0; @(negedge clk);
        chk("lit_rr_rv1", 32'(redirect_valid), 32'd1);
        rst = 1'b1; step(); rst = 1'b0; @(negedge clk);
        chk("lit_rr_rv0", 32'(redirect_valid), 32'd0);
        chk("lit_rr_cnt", 32'(branch_cnt), 32'd0);
        chk("lit_rr_tcnt", 32'(taken_cnt), 32'd0);

        // Counter wrap: 17 taken branches on a 4-bit counter
        redirect_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            issue(2'd1, 1'b1, 32'h0, 32'h8, 32'h0);
            step(); ex_valid = 1'b0; step();
        end
        @(negedge clk);
        chk("lit_wrap_bcnt", 32'(branch_cnt), 32'd1);
        chk("lit_wrap_tcnt", 32'(taken_cnt), 32'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            rst            = ($urandom_range(0, 99) == 0);
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_kind        = 2'($urandom_range(0, 3));
            br_en          = 1'($urandom);
            pc_ex          = $urandom & 32'hFFFF_FFFC;
            imm            = $urandom & 32'h0000_0FFE;
            rs1            = $urandom;
            redirect_ready = ($urandom_range(0, 9) < 7);
        end
        step(); rst = 1'b0; ex_valid = 1'b0;
        step(); @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
